// File: rtl/store_merge_rmw_if.sv
// Store request / data memory bundle for the sub-word store merge unit.
// slave: store unit side; master: control unit + memory side.
interface store_merge_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic              done;
    logic              align_err;

    modport slave (
        input  start, size, addr, wdata, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, busy, done, align_err
    );

    modport master (
        output start, size, addr, wdata, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy, done, align_err
    );
endinterface

// File: rtl/store_merge_rmw.sv
// sb/sh/sw store unit: word stores write directly, sub-word stores do a
// read-modify-write of the addressed word. Ports: clk, reset, bus (slave).
module store_merge_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    store_merge_rmw_if.slave bus
);
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        IDLE, READ, WAIT, WRITE, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [15:0]       data_q, data_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       merged;
    logic              bad_req;

    assign bad_req = (bus.size == 2'b11)
                   || (bus.size == SZ_WORD && bus.addr[1:0] != 2'b00)
                   || (bus.size == SZ_HALF && bus.addr[0]);

    // Insert the stored lane into the word just read back.
    always_comb begin
        merged = bus.mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0] = data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        merge_d = merge_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d = bus.addr;
                    size_d = bus.size;
                    data_d = bus.wdata[15:0];
                    if (bad_req) begin
                        state_d = ERR;
                    end else if (bus.size == SZ_WORD) begin
                        merge_d = bus.wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:  state_d = WAIT;
            WAIT: begin
                merge_d = merged;
                state_d = WRITE;
            end
            WRITE: state_d = IDLE;
            ERR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            merge_q <= merge_d;
        end
    end

    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = merge_q;
    assign bus.mem_wr    = (state_q == WRITE);
    assign bus.done      = (state_q == WRITE);
    assign bus.align_err = (state_q == ERR);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_store_merge_rmw.sv
// Directed vector bench for store_merge_rmw with a 1-cycle-latency
// data memory model.
module tb_store_merge_rmw;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_merge_rmw_if #(.ADDR_W(32)) bus ();
    store_merge_rmw #(.ADDR_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    logic [31:0] mem [0:1023];
    logic [31:0] rdata_q;
    assign bus.mem_rdata = rdata_q;
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        else            rdata_q <= mem[bus.mem_addr[11:2]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp;
        int          cyc;
        logic        err;
        logic        pulse;
    } vec_t;

    vec_t vecs [11];

    task automatic run(input vec_t v, output int done_c, output int err_c,
                       output int wr_n, output int busy_n,
                       output logic [31:0] wr_d, output logic [31:0] wr_a);
        done_c = -1; err_c = -1; wr_n = 0; busy_n = 0;
        wr_d = 'x; wr_a = 'x;
        mem[v.addr[11:2]] = v.init;
        @(negedge clk);
        bus.start = 1'b1; bus.size = v.size;
        bus.addr = v.addr; bus.wdata = v.wdata;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.done && done_c < 0) done_c = c;
            if (bus.align_err && err_c < 0) err_c = c;
            if (bus.busy) busy_n++;
            if (bus.mem_wr) begin
                wr_n++; wr_d = bus.mem_wdata; wr_a = bus.mem_addr;
            end
            // Competing request while busy must be dropped.
            bus.start = v.pulse && c <= 3;
            bus.size  = 2'b10;
            bus.addr  = 32'h104;
            bus.wdata = 32'h0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int dc, ec, wn, bn;
        logic [31:0] wd, wa;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        vecs[0]  = '{2'b10, 32'h100, 32'hAABBCCDD, 32'h11223344, 32'h112233DD, 3, 0, 0};
        vecs[1]  = '{2'b10, 32'h101, 32'hAABBCCDD, 32'h11223344, 32'h1122DD44, 3, 0, 0};
        vecs[2]  = '{2'b10, 32'h102, 32'hAABBCCDD, 32'h11223344, 32'h11DD3344, 3, 0, 0};
        vecs[3]  = '{2'b10, 32'h103, 32'hAABBCCDD, 32'h11223344, 32'hDD223344, 3, 0, 0};
        vecs[4]  = '{2'b01, 32'h200, 32'hFFFF8001, 32'h11223344, 32'h11228001, 3, 0, 0};
        vecs[5]  = '{2'b01, 32'h202, 32'hFFFF8001, 32'h11223344, 32'h80013344, 3, 0, 0};
        vecs[6]  = '{2'b00, 32'h300, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF, 1, 0, 0};
        vecs[7]  = '{2'b00, 32'h302, 32'hDEADBEEF, 32'h11223344, 32'h11223344, 1, 1, 0};
        vecs[8]  = '{2'b01, 32'h201, 32'hFFFF8001, 32'h11223344, 32'h11223344, 1, 1, 0};
        vecs[9]  = '{2'b11, 32'h100, 32'hAABBCCDD, 32'h11223344, 32'h11223344, 1, 1, 0};
        vecs[10] = '{2'b10, 32'h101, 32'h12345678, 32'h11223344, 32'h11227844, 3, 0, 1};

        bus.start = 1'b0; bus.size = 2'b00;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst flags", {28'h0, bus.mem_wr, bus.busy, bus.done, bus.align_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i], dc, ec, wn, bn, wd, wa);
            if (vecs[i].err) begin
                chk($sformatf("v%0d err cycle", i), ec, 1);
                chk($sformatf("v%0d err writes", i), wn, 0);
                chk($sformatf("v%0d err done", i), dc, -1);
                chk($sformatf("v%0d err busy", i), bn, 1);
            end else begin
                chk($sformatf("v%0d done cycle", i), dc, vecs[i].cyc);
                chk($sformatf("v%0d writes", i), wn, 1);
                chk($sformatf("v%0d wdata", i), wd, vecs[i].exp);
                chk($sformatf("v%0d waddr", i), wa, {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d busy cycles", i), bn, vecs[i].cyc);
                chk($sformatf("v%0d no err", i), ec, -1);
            end
            chk($sformatf("v%0d mem word", i), mem[vecs[i].addr[11:2]], vecs[i].exp);
        end

        // Reset asserted during WAIT: no write may follow.
        mem[32'h104 >> 2] = 32'h55667788;
        @(negedge clk);
        bus.start = 1'b1; bus.size = 2'b10;
        bus.addr = 32'h105; bus.wdata = 32'h000000AA;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("wait busy", bus.busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstwait flags", {28'h0, bus.mem_wr, bus.busy, bus.done, bus.align_err}, 32'h0);
        chk("rstwait mem_addr", bus.mem_addr, 32'h0);
        chk("rstwait mem_wdata", bus.mem_wdata, 32'h0);
        wn = 0;
        repeat (4) begin
            if (bus.mem_wr) wn++;
            @(posedge clk); #1;
        end
        chk("rstwait writes", wn, 0);
        chk("rstwait mem", mem[32'h104 >> 2], 32'h55667788);

        // start together with reset: dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.size = 2'b00;
        bus.addr = 32'h300; bus.wdata = 32'h01020304;
        reset = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; reset = 1'b0;
        chk("start+rst busy", bus.busy, 1'b0);
        chk("start+rst wr", bus.mem_wr, 1'b0);

        // start held high: word store repeats every other cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.size = 2'b00;
        bus.addr = 32'h304; bus.wdata = 32'hCAFEF00D;
        wn = 0; dc = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 5; c++) begin
            if (bus.mem_wr) begin
                wn++;
                dc = dc * 10 + c;
            end
            if (c == 3) bus.start = 1'b0;
            @(posedge clk); #1;
        end
        chk("b2b writes", wn, 2);
        chk("b2b cycles", dc, 13);
        chk("b2b mem", mem[32'h304 >> 2], 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
